// File: rtl/sincos_pkg.sv
// Shared Q-format constants and the tracking-stage record for the sin/cos arbiter.
package sincos_pkg;
    localparam int ANGLE_W   = 16;
    localparam int FRAC_W    = 13;
    localparam int PI_Q      = 25736;
    localparam int HALF_PI_Q = 12868;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_MAX_W  = 3;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic                neg;
    } stage_t;
endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational grant searched upward from a registered pointer.
module rr_arbiter #(
    parameter  int N   = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    output logic [N-1:0]   grant,
    output logic           grant_vld,
    output logic [IDW-1:0] grant_id
);
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] cand;
    int             scan_idx;

    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= N) scan_idx = scan_idx - N;
            cand = IDW'(scan_idx);
            if (!grant_vld && req[cand] && !reset) begin
                grant_vld   = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld) ptr_d = (grant_id == IDW'(N - 1)) ? '0 : grant_id + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end
endmodule

// File: rtl/sin_cos_arbiter.sv
// Shares one pipelined CORDIC sin/cos core among N_REQ requesters with quadrant folding
// and per-operation tracking so each result returns to its issuer.
module sin_cos_arbiter #(
    parameter int N_REQ     = 4,
    parameter int LATENCY   = 4,
    parameter int PI_Q      = sincos_pkg::PI_Q,
    parameter int HALF_PI_Q = sincos_pkg::HALF_PI_Q
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [16*N_REQ-1:0] req_angle,
    output logic [N_REQ-1:0]    req_ready,
    output logic [N_REQ-1:0]    resp_valid,
    output logic [15:0]         resp_sin,
    output logic [15:0]         resp_cos,
    output logic [15:0]         cordic_a,
    input  logic [15:0]         cordic_s,
    input  logic [15:0]         cordic_c,
    output logic                busy
);
    import sincos_pkg::*;

    localparam int ID_W = $clog2(N_REQ);
    localparam logic signed [ANGLE_W:0] PI_W       = (ANGLE_W+1)'(PI_Q);
    localparam logic signed [ANGLE_W:0] HALF_W     = (ANGLE_W+1)'(HALF_PI_Q);
    localparam logic signed [ANGLE_W:0] NEG_HALF_W = (ANGLE_W+1)'(-HALF_PI_Q);

    logic                      grant_vld;
    logic [ID_W-1:0]           grant_id;
    logic signed [ANGLE_W-1:0] sel_angle;
    logic signed [ANGLE_W:0]   angle_ext, folded;
    logic                      fold_neg;
    logic                      fold_unused;
    logic [ANGLE_W-1:0]        cordic_a_d, cordic_a_q;
    stage_t                    pipe_d [LATENCY+1];
    stage_t                    pipe_q [LATENCY+1];
    stage_t                    tail;
    logic [N_REQ-1:0]          resp_valid_d, resp_valid_q;
    logic [15:0]               resp_sin_d, resp_sin_q, resp_cos_d, resp_cos_q;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (req_valid),
        .grant     (req_ready),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    // Fold into [-pi/2, pi/2]; sin and cos both flip sign across a pi shift.
    always_comb begin
        sel_angle = req_angle[ANGLE_W*int'(grant_id) +: ANGLE_W];
        angle_ext = {sel_angle[ANGLE_W-1], sel_angle};
        folded    = angle_ext;
        fold_neg  = 1'b0;
        if (angle_ext > HALF_W) begin
            folded   = angle_ext - PI_W;
            fold_neg = 1'b1;
        end else if (angle_ext < NEG_HALF_W) begin
            folded   = angle_ext + PI_W;
            fold_neg = 1'b1;
        end
        cordic_a_d = grant_vld ? folded[ANGLE_W-1:0] : cordic_a_q;
    end
    assign fold_unused = folded[ANGLE_W];

    always_comb begin
        pipe_d[0].valid = grant_vld;
        pipe_d[0].id    = ID_MAX_W'(grant_id);
        pipe_d[0].neg   = fold_neg;
        for (int k = 1; k <= LATENCY; k++) pipe_d[k] = pipe_q[k-1];
    end

    // Tail stage lines up with the core output for the same issue.
    assign tail = pipe_q[LATENCY];

    always_comb begin
        resp_valid_d = '0;
        resp_sin_d   = resp_sin_q;
        resp_cos_d   = resp_cos_q;
        if (tail.valid) begin
            resp_valid_d = N_REQ'(1) << tail.id;
            resp_sin_d   = tail.neg ? (16'd0 - cordic_s) : cordic_s;
            resp_cos_d   = tail.neg ? (16'd0 - cordic_c) : cordic_c;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k <= LATENCY; k++) pipe_q[k] <= '0;
            cordic_a_q   <= '0;
            resp_valid_q <= '0;
            resp_sin_q   <= '0;
            resp_cos_q   <= '0;
        end else begin
            for (int k = 0; k <= LATENCY; k++) pipe_q[k] <= pipe_d[k];
            cordic_a_q   <= cordic_a_d;
            resp_valid_q <= resp_valid_d;
            resp_sin_q   <= resp_sin_d;
            resp_cos_q   <= resp_cos_d;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= LATENCY; k++) busy = busy | pipe_q[k].valid;
    end

    assign cordic_a   = cordic_a_q;
    assign resp_valid = resp_valid_q;
    assign resp_sin   = resp_sin_q;
    assign resp_cos   = resp_cos_q;
endmodule

// File: tb/tb_sin_cos_arbiter.sv
// Scoreboard bench for sin_cos_arbiter with an ideal fixed-latency sin/cos core model.
module tb_sin_cos_arbiter;
    localparam int N   = 4;
    localparam int LAT = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  req_valid;
    logic [16*N-1:0] req_angle;
    logic [N-1:0]  req_ready;
    logic [N-1:0]  resp_valid;
    logic [15:0]   resp_sin, resp_cos, cordic_a, cordic_s, cordic_c;
    logic          busy;

    always #5 clk = ~clk;

    sin_cos_arbiter #(.N_REQ(N), .LATENCY(LAT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_angle  (req_angle),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_sin   (resp_sin),
        .resp_cos   (resp_cos),
        .cordic_a   (cordic_a),
        .cordic_s   (cordic_s),
        .cordic_c   (cordic_c),
        .busy       (busy)
    );

    function automatic int qround(real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction
    function automatic int ref_sin(int a);
        return qround($sin($itor(a) / 8192.0) * 8192.0);
    endfunction
    function automatic int ref_cos(int a);
        return qround($cos($itor(a) / 8192.0) * 8192.0);
    endfunction
    function automatic int fold(int a);
        if (a > 12868)  return a - 25736;
        if (a < -12868) return a + 25736;
        return a;
    endfunction

    // Ideal core: input registered at the edge after issue, output valid LAT cycles later.
    logic [15:0] core_s [LAT];
    logic [15:0] core_c [LAT];
    always @(posedge clk) begin
        core_s[0] <= 16'(ref_sin(int'($signed(cordic_a))));
        core_c[0] <= 16'(ref_cos(int'($signed(cordic_a))));
        for (int k = 1; k < LAT; k++) begin
            core_s[k] <= core_s[k-1];
            core_c[k] <= core_c[k-1];
        end
    end
    assign cordic_s = core_s[LAT-1];
    assign cordic_c = core_c[LAT-1];

    typedef struct {
        int id;
        int angle;
        int due;
    } exp_t;
    exp_t sbq[$];

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int ptr_m   = 0;
    int last_a_m = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int want);
        vectors++;
        if (act != want) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d", nm, cyc, act, want);
        end
    endtask

    task automatic check_tol(input string nm, input int act, input int want, input int tol);
        vectors++;
        if (act > want + tol || act < want - tol) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0d, want %0d +/- %0d", nm, cyc, act, want, tol);
        end
    endtask

    // Monitor: busy every cycle, responses popped in issue order.
    initial begin
        exp_t e;
        int   bexp;
        forever begin
            @(negedge clk);
            bexp = 0;
            foreach (sbq[i]) if (sbq[i].due > cyc) bexp = 1;
            check("busy", int'(busy), bexp);
            if (resp_valid != '0) begin
                if (sbq.size() == 0) begin
                    check("spurious_resp", int'(resp_valid), 0);
                end else begin
                    e = sbq.pop_front();
                    check("resp_id", int'(resp_valid), 1 << e.id);
                    check("resp_latency", cyc, e.due);
                    check_tol("resp_sin", int'($signed(resp_sin)), ref_sin(e.angle), 2);
                    check_tol("resp_cos", int'($signed(resp_cos)), ref_cos(e.angle), 2);
                end
            end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
                e = sbq.pop_front();
                check("missing_resp", 0, 1 << e.id);
            end
        end
    end

    task automatic drive(input logic [N-1:0] v, input logic [16*N-1:0] angs, input logic rst,
                         output int gid);
        int a;
        @(negedge clk);
        #2;
        reset     = rst;
        req_valid = v;
        req_angle = angs;
        gid = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr_m + k) % N;
                if (gid < 0 && v[idx]) gid = idx;
            end
        end
        #1;
        check("req_ready", int'(req_ready), (gid < 0) ? 0 : (1 << gid));
        @(posedge clk);
        #1;
        if (rst) begin
            sbq.delete();
            ptr_m    = 0;
            last_a_m = 0;
            check("reset_cordic_a", int'(cordic_a), 0);
            check("reset_resp_sin", int'(resp_sin), 0);
            check("reset_resp_cos", int'(resp_cos), 0);
            check("reset_resp_valid", int'(resp_valid), 0);
        end else if (gid >= 0) begin
            a = int'($signed(angs[16*gid +: 16]));
            sbq.push_back('{id: gid, angle: a, due: cyc + LAT + 1});
            ptr_m    = (gid + 1) % N;
            last_a_m = fold(a);
            check("cordic_a", int'($signed(cordic_a)), last_a_m);
        end else begin
            check("cordic_a_hold", int'($signed(cordic_a)), last_a_m);
        end
    endtask

    task automatic idle(input int n);
        int g;
        for (int i = 0; i < n; i++) drive('0, '0, 1'b0, g);
    endtask

    initial begin
        int g, prevg;
        logic [N-1:0]    pend;
        logic [16*N-1:0] angs;
        logic [15:0]     ang16;
        int bnd[8] = '{12868, -12869, -12868, 12869, 32767, -32768, 8192, -8192};

        reset     = 1'b1;
        req_valid = '0;
        req_angle = '0;

        drive(4'hF, {$urandom, $urandom}, 1'b1, g);
        drive('0, '0, 1'b1, g);

        drive(4'b0001, '0, 1'b0, g);
        idle(8);

        ang16 = 16'd16384;
        drive(4'b0100, {16'd0, ang16, 32'd0}, 1'b0, g);
        idle(8);

        for (int i = 0; i < 8; i++) begin
            ang16 = 16'(bnd[i]);
            angs  = '0;
            angs[16*(i%N) +: 16] = ang16;
            drive(N'(1) << (i % N), angs, 1'b0, g);
        end
        idle(8);

        drive('0, '0, 1'b1, g);
        pend = 4'hF;
        angs = {$urandom, $urandom};
        for (int k = 0; k < N; k++) begin
            drive(pend, angs, 1'b0, g);
            check("simul_grant", g, k);
            if (g >= 0) pend[g] = 1'b0;
        end
        idle(8);

        prevg = -1;
        for (int i = 0; i < 12; i++) begin
            drive(4'b1010, {$urandom, $urandom}, 1'b0, g);
            if (prevg >= 0) check("fair_alt", g, (prevg == 1) ? 3 : 1);
            prevg = g;
        end
        idle(8);

        for (int i = 0; i < 3; i++) drive(4'b0111, {$urandom, $urandom}, 1'b0, g);
        idle(2);
        drive('0, '0, 1'b1, g);
        idle(8);
        for (int i = 0; i < 4; i++) drive(4'hF, {$urandom, $urandom}, 1'b0, g);
        idle(8);

        for (int i = 0; i < 400; i++) begin
            pend = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom_range(0, 15));
            drive(pend, {$urandom, $urandom}, 1'b0, g);
        end
        idle(10);

        check("drain", sbq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
